// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: bundles the PS/2 line inputs with the decoded key-event outputs.
// master = keyboard/line side, slave = receiver side.
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_valid;
    logic       key_release;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  key_code, key_extended, key_valid, key_release, parity_err, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_code, key_extended, key_valid, key_release, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard frame receiver with E0/F0 prefix resolution.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppresses repeated make codes).
module ps2_key_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_key_receiver_if.slave bus
);
    localparam int unsigned FiltW   = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  CodeExt = 8'hE0;
    localparam logic [7:0]  CodeBrk = 8'hF0;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]       r_clk_sync, r_dat_sync;
    logic [FiltW-1:0] r_filt_cnt;
    logic             r_filt_clk, r_fall, r_fall_dat;

    state_e           r_state, w_state_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_par_ok, w_par_ok_nxt;
    logic [TmoW-1:0]  r_tmo, w_tmo_nxt;
    logic             w_deliver, w_perr, w_ferr;

    logic [7:0]       r_key_code, w_code_nxt;
    logic             r_key_ext, w_ext_nxt;
    logic             r_key_valid, w_valid_nxt;
    logic             r_key_rel, w_rel_nxt;
    logic             r_perr, r_ferr;
    logic             r_ext_pend, w_ext_pend_nxt;
    logic             r_brk_pend, w_brk_pend_nxt;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]       r_last, w_last_nxt;   // {extended, code} of the last make
`endif

    // Synchronize both lines and debounce ps2_clk; emit a one-cycle fall strobe with its data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_cnt <= '0;
            r_filt_clk <= 1'b1;
            r_fall     <= 1'b0;
            r_fall_dat <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
            r_fall     <= 1'b0;
            r_fall_dat <= r_dat_sync[1];
            if (r_clk_sync[1] != r_filt_clk) begin
                if (r_filt_cnt == FiltW'(FILTER_LEN - 1)) begin
                    r_filt_cnt <= '0;
                    r_filt_clk <= r_clk_sync[1];
                    r_fall     <= ~r_clk_sync[1];
                end else begin
                    r_filt_cnt <= r_filt_cnt + FiltW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Frame FSM next state, bit shifting, parity/stop checks and mid-frame timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_ok_nxt  = r_par_ok;
        w_deliver     = 1'b0;
        w_perr        = 1'b0;
        w_ferr        = 1'b0;
        if (r_state == StIdle || r_fall) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + TmoW'(1);
        end
        if (r_state != StIdle && !r_fall && r_tmo == TmoW'(TIMEOUT_CYCLES)) begin
            w_state_nxt = StIdle;
            w_tmo_nxt   = '0;
            w_ferr      = 1'b1;
        end else if (r_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!r_fall_dat) begin
                        w_state_nxt   = StData;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
                StData: begin
                    w_shift_nxt   = {r_fall_dat, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = StParity;
                end
                StParity: begin
                    w_par_ok_nxt = ^{r_shift, r_fall_dat};
                    w_state_nxt  = StStop;
                end
                StStop: begin
                    w_state_nxt = StIdle;
                    if (!r_fall_dat) begin
                        w_ferr = 1'b1;
                    end else if (!r_par_ok) begin
                        w_perr = 1'b1;
                    end else begin
                        w_deliver = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Prefix resolution: accumulate E0/F0, emit make/break on the first non-prefix byte.
    always_comb begin
        w_code_nxt     = r_key_code;
        w_ext_nxt      = r_key_ext;
        w_valid_nxt    = 1'b0;
        w_rel_nxt      = 1'b0;
        w_ext_pend_nxt = r_ext_pend;
        w_brk_pend_nxt = r_brk_pend;
`ifdef PS2_TYPEMATIC_FILTER_EN
        w_last_nxt     = r_last;
`endif
        if (w_ferr || w_perr) begin
            w_ext_pend_nxt = 1'b0;
            w_brk_pend_nxt = 1'b0;
        end else if (w_deliver) begin
            if (r_shift == CodeExt) begin
                w_ext_pend_nxt = 1'b1;
            end else if (r_shift == CodeBrk) begin
                w_brk_pend_nxt = 1'b1;
            end else begin
                w_ext_pend_nxt = 1'b0;
                w_brk_pend_nxt = 1'b0;
                if (r_brk_pend) begin
                    w_code_nxt = r_shift;
                    w_ext_nxt  = r_ext_pend;
                    w_rel_nxt  = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (r_last == {r_ext_pend, r_shift}) w_last_nxt = '0;
`endif
                end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    // A repeat of the held-down key is dropped entirely.
                    if (r_last != {r_ext_pend, r_shift}) begin
                        w_code_nxt  = r_shift;
                        w_ext_nxt   = r_ext_pend;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = {r_ext_pend, r_shift};
                    end
`else
                    w_code_nxt  = r_shift;
                    w_ext_nxt   = r_ext_pend;
                    w_valid_nxt = 1'b1;
`endif
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_ok    <= 1'b0;
            r_tmo       <= '0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_rel   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_last      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_ok    <= w_par_ok_nxt;
            r_tmo       <= w_tmo_nxt;
            r_key_code  <= w_code_nxt;
            r_key_ext   <= w_ext_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_rel   <= w_rel_nxt;
            r_perr      <= w_perr;
            r_ferr      <= w_ferr;
            r_ext_pend  <= w_ext_pend_nxt;
            r_brk_pend  <= w_brk_pend_nxt;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_last      <= w_last_nxt;
`endif
        end
    end

    assign bus.key_code     = r_key_code;
    assign bus.key_extended = r_key_ext;
    assign bus.key_valid    = r_key_valid;
    assign bus.key_release  = r_key_rel;
    assign bus.parity_err   = r_perr;
    assign bus.frame_err    = r_ferr;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: scoreboard bench driving PS/2 frames and checking decoded events.
module tb_ps2_key_receiver;
    localparam int unsigned FilterLen     = 8;
    localparam int unsigned TimeoutCycles = 600;
    localparam int unsigned HalfBit       = 40;

    localparam logic [1:0] EvMake  = 2'd0;
    localparam logic [1:0] EvBreak = 2'd1;
    localparam logic [1:0] EvPerr  = 2'd2;
    localparam logic [1:0] EvFerr  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ps2_key_receiver_if bus();

    ps2_key_receiver #(
        .FILTER_LEN     (FilterLen),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_make_seen = 0;
    int n_break_seen = 0;
    ev_t sb[$];

    // Reference model state
    logic       m_ext_pend, m_brk_pend, m_ext;
    logic [7:0] m_code;
    logic [8:0] m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ext_pend = 1'b0;
        m_brk_pend = 1'b0;
        m_ext      = 1'b0;
        m_code     = 8'h00;
        m_last     = '0;
        sb.delete();
    endtask

    task automatic push_ev(input logic [1:0] k);
        ev_t e;
        e.kind = k;
        e.code = m_code;
        e.ext  = m_ext;
        sb.push_back(e);
    endtask

    // err: 0 = good frame, 1 = parity error, 2 = frame error / timeout
    task automatic model_byte(input logic [7:0] b, input int err);
        if (err != 0) begin
            push_ev(err == 1 ? EvPerr : EvFerr);
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else begin
            if (m_brk_pend) begin
                m_code = b;
                m_ext  = m_ext_pend;
                push_ev(EvBreak);
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (m_last == {m_ext_pend, b}) m_last = '0;
`endif
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (m_last != {m_ext_pend, b}) begin
                    m_code = b;
                    m_ext  = m_ext_pend;
                    m_last = {m_ext_pend, b};
                    push_ev(EvMake);
                end
`else
                m_code = b;
                m_ext  = m_ext_pend;
                push_ev(EvMake);
`endif
            end
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end
    endtask

    // One PS/2 bit cell; glitch adds sub-filter-length spikes in both clock phases.
    task automatic ps2_bit(input logic d, input logic glitch);
        bus.ps2_data = d;
        if (glitch) begin
            repeat (10) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (FilterLen - 1) @(posedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HalfBit - 10 - (FilterLen - 1)) @(posedge clk);
        end else begin
            repeat (HalfBit) @(posedge clk);
        end
        bus.ps2_clk = 1'b0;
        if (glitch) begin
            repeat (10) @(posedge clk);
            bus.ps2_clk = 1'b1;
            repeat (FilterLen - 1) @(posedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HalfBit - 10 - (FilterLen - 1)) @(posedge clk);
        end else begin
            repeat (HalfBit) @(posedge clk);
        end
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input logic glitch);
        model_byte(b, bad_stop ? 2 : (bad_par ? 1 : 0));
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ bad_par, glitch);
        ps2_bit(~bad_stop, glitch);
        bus.ps2_data = 1'b1;
        repeat (HalfBit) @(posedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_code", bus.key_code, 8'h00);
        check_eq("rst_ext", bus.key_extended, 0);
        check_eq("rst_valid", bus.key_valid, 0);
        check_eq("rst_release", bus.key_release, 0);
        check_eq("rst_perr", bus.parity_err, 0);
        check_eq("rst_ferr", bus.frame_err, 0);
    endtask

    // Scoreboard monitor: every output pulse pops one expected event.
    always @(negedge clk) begin
        int n;
        logic [1:0] k;
        ev_t e;
        if (rst_n) begin
            n = int'(bus.key_valid) + int'(bus.key_release) + int'(bus.parity_err) +
                int'(bus.frame_err);
            if (n > 1) check_eq("one_pulse", n, 1);
            if (n != 0) begin
                k = bus.key_valid ? EvMake : bus.key_release ? EvBreak :
                    bus.parity_err ? EvPerr : EvFerr;
                if (bus.key_valid) n_make_seen++;
                if (bus.key_release) n_break_seen++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_eq("ev_kind", {30'd0, k}, {30'd0, e.kind});
                    check_eq("ev_code", {24'd0, bus.key_code}, {24'd0, e.code});
                    check_eq("ev_ext", {31'd0, bus.key_extended}, {31'd0, e.ext});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mk0;
        int br0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs();

        // Plain make, break, extended make
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        drain();
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        drain();

        // Parity error, and error frames clearing pending prefixes
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0, 1'b0);
        drain();

        // Bad start bit while idle
        model_byte(8'h00, 2);
        ps2_bit(1'b1, 1'b0);
        repeat (HalfBit) @(posedge clk);
        drain();

        // Timeout mid-frame, then recovery
        model_byte(8'h00, 2);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        bus.ps2_data = 1'b1;
        repeat (TimeoutCycles + 10) @(posedge clk);
        drain();
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0);
        drain();

        // Glitch rejection
        send_frame(8'h45, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset mid-frame
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        @(posedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (HalfBit) @(posedge clk);
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        drain();

        // Typematic sequence
        mk0 = n_make_seen;
        br0 = n_break_seen;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
        check_eq("typematic_makes", n_make_seen - mk0, 2);
`else
        check_eq("typematic_makes", n_make_seen - mk0, 4);
`endif
        check_eq("typematic_breaks", n_break_seen - br0, 1);

        repeat (20) @(posedge clk);
        check_eq("final_queue", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
